// File: rtl/ca_pkg.sv
// Shared types and constants for the ring cellular-automaton runner.
package ca_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ca_state_t;

  localparam logic [3:0] RULE_XOR  = 4'b0110;
  localparam logic [3:0] RULE_ID   = 4'b1010;
  localparam logic [3:0] RULE_ROTR = 4'b1100;

endpackage

// File: rtl/ca_next_state.sv
// Combinational next-generation logic: each cell looks up the rule table
// with {right neighbour, self}; the top cell wraps around to cell 0.
module ca_next_state #(
  parameter int N = 8
) (
  input  logic [N-1:0] state,
  input  logic [3:0]   rule,
  output logic [N-1:0] next
);

  for (genvar i = 0; i < N; i++) begin : g_cell
    assign next[i] = rule[{state[(i + 1) % N], state[i]}];
  end

endmodule

// File: rtl/ca_runner.sv
// Runs a 1-D ring automaton for a latched number of generations.
// Build option CA_RUNNER_HALT_EN: stop early once the ring reaches a fixed point.
module ca_runner
  import ca_pkg::*;
#(
  parameter int N  = 8,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [N-1:0]  seed,
  input  logic [3:0]    rule,
  input  logic [CW-1:0] gens,
  output logic          busy,
  output logic          done,
  output logic [N-1:0]  state_q,
  output logic [CW-1:0] gen_cnt,
  output logic          stable
);

  ca_state_t     fsm;
  logic [3:0]    rule_l;
  logic [CW-1:0] gens_l;
  logic [N-1:0]  next;
  logic [CW-1:0] gen_inc;
  logic          fixed_pt;

  ca_next_state #(.N(N)) u_next (
    .state (state_q),
    .rule  (rule_l),
    .next  (next)
  );

  assign gen_inc = gen_cnt + CW'(1);

`ifdef CA_RUNNER_HALT_EN
  assign fixed_pt = (next == state_q);
`else
  assign fixed_pt = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm     <= IDLE;
      state_q <= '0;
      gen_cnt <= '0;
      rule_l  <= '0;
      gens_l  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      stable  <= 1'b0;
    end else begin
      case (fsm)
        IDLE: begin
          if (start) begin
            state_q <= seed;
            rule_l  <= rule;
            gens_l  <= gens;
            gen_cnt <= '0;
            stable  <= 1'b0;
            if (gens == '0) begin
              fsm  <= DONE;
              done <= 1'b1;
            end else begin
              fsm  <= RUN;
              busy <= 1'b1;
            end
          end
        end
        RUN: begin
          state_q <= next;
          gen_cnt <= gen_inc;
          // Counter stops at the latched target, so it never wraps.
          if (gen_inc == gens_l || fixed_pt) begin
            fsm    <= DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            stable <= fixed_pt;
          end
        end
        DONE: begin
          fsm  <= IDLE;
          done <= 1'b0;
        end
        default: begin
          fsm  <= IDLE;
          busy <= 1'b0;
          done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ca_runner.sv
// Self-checking bench for ca_runner: directed vector table, reset corner case
// and randomized runs against a generation-by-generation reference model.
module tb_ca_runner;
  import ca_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] seed;
  logic [3:0] rule;
  logic [7:0] gens;
  logic       busy, done, stable;
  logic [7:0] state_q, gen_cnt;

  int checks = 0;
  int failures = 0;

  ca_runner #(.N(8), .CW(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .seed    (seed),
    .rule    (rule),
    .gens    (gens),
    .busy    (busy),
    .done    (done),
    .state_q (state_q),
    .gen_cnt (gen_cnt),
    .stable  (stable)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] seed;
    logic [3:0] rule;
    logic [7:0] gens;
    logic [7:0] exp_state;
    logic [7:0] exp_cnt;
    logic       exp_stable;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One generation from the rule definition: bit value of rule at 2*right+self.
  function automatic logic [7:0] model_step(input logic [7:0] s, input logic [3:0] r);
    logic [7:0] n;
    int idx;
    for (int i = 0; i < 8; i++) begin
      idx = 2 * int'(s[(i + 1) % 8]) + int'(s[i]);
      n[i] = r[idx];
    end
    return n;
  endfunction

  task automatic model_run(input logic [7:0] sd, input logic [3:0] r, input logic [7:0] g,
                           output logic [7:0] fs, output logic [7:0] fc, output logic fst);
    logic [7:0] s, nx;
    int cnt;
    s = sd; cnt = 0; fst = 1'b0;
    while (cnt < int'(g)) begin
      nx = model_step(s, r);
      cnt++;
`ifdef CA_RUNNER_HALT_EN
      if (nx == s) begin
        fst = 1'b1;
        s = nx;
        break;
      end
`endif
      s = nx;
    end
    fs = s;
    fc = 8'(cnt);
  endtask

  // Launch, follow the run cycle by cycle (perturbing start/seed/rule/gens
  // while it runs), then check the completion cycle and the hold afterwards.
  task automatic run_check(input string name, input logic [7:0] sd, input logic [3:0] r,
                           input logic [7:0] g, input logic [7:0] ef, input logic [7:0] ec,
                           input logic est, input bit perturb);
    logic [7:0] s;
    int j;
    bit finished;
    @(negedge clk);
    start = 1'b1; seed = sd; rule = r; gens = g;
    @(posedge clk);
    #1;
    start = 1'b0;
    seed = 8'($urandom); rule = 4'($urandom); gens = 8'($urandom);
    s = sd; j = 0; finished = 1'b0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge clk);
      if (done) begin
        start = 1'b0;
        finished = 1'b1;
        break;
      end
      check({name, " busy"}, 32'(busy), 32'd1);
      check({name, " trace"}, 32'(state_q), 32'(s));
      check({name, " gen_cnt_trace"}, 32'(gen_cnt), 32'(j));
      if (perturb) begin
        start = 1'($urandom_range(0, 1));
        seed = 8'($urandom);
      end
      s = model_step(s, r);
      j++;
    end
    start = 1'b0;
    if (!finished) begin
      check({name, " timeout"}, 32'd0, 32'd1);
      return;
    end
    check({name, " latency"}, 32'(j), 32'(ec));
    check({name, " state"}, 32'(state_q), 32'(ef));
    check({name, " gen_cnt"}, 32'(gen_cnt), 32'(ec));
    check({name, " stable"}, 32'(stable), 32'(est));
    check({name, " busy_done"}, 32'(busy), 32'd0);
    @(negedge clk);
    check({name, " done_pulse"}, 32'(done), 32'd0);
    check({name, " hold_state"}, 32'(state_q), 32'(ef));
    check({name, " hold_cnt"}, 32'(gen_cnt), 32'(ec));
  endtask

  initial begin
    logic [7:0] fs, fc;
    logic fst;
    bit saw_done;

    vecs[0] = '{8'h01, RULE_XOR,  8'd2,  8'h41, 8'd2, 1'b0};
    vecs[1] = '{8'h01, RULE_ROTR, 8'd8,  8'h01, 8'd8, 1'b0};
    vecs[2] = '{8'hA5, RULE_XOR,  8'd0,  8'hA5, 8'd0, 1'b0};
`ifdef CA_RUNNER_HALT_EN
    vecs[3] = '{8'h3C, RULE_ID,   8'd10, 8'h3C, 8'd1, 1'b1};
`else
    vecs[3] = '{8'h3C, RULE_ID,   8'd10, 8'h3C, 8'd10, 1'b0};
`endif
    vecs[4] = '{8'h01, RULE_ROTR, 8'd3,  8'h20, 8'd3, 1'b0};

    reset = 1'b1; start = 1'b0; seed = '0; rule = '0; gens = '0;
    repeat (2) @(negedge clk);
    check("reset state_q", 32'(state_q), 32'd0);
    check("reset gen_cnt", 32'(gen_cnt), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset stable", 32'(stable), 32'd0);
    reset = 1'b0;

    foreach (vecs[k])
      run_check($sformatf("vec%0d", k), vecs[k].seed, vecs[k].rule, vecs[k].gens,
                vecs[k].exp_state, vecs[k].exp_cnt, vecs[k].exp_stable, 1'b0);

    // Restart attempts and seed changes during a run must not disturb it.
    run_check("perturbed", 8'h01, RULE_ROTR, 8'd8, 8'h01, 8'd8, 1'b0, 1'b1);

    // Asynchronous reset in the middle of a run.
    @(negedge clk);
    start = 1'b1; seed = 8'h01; rule = RULE_ROTR; gens = 8'd8;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("midrun_reset state_q", 32'(state_q), 32'd0);
    check("midrun_reset gen_cnt", 32'(gen_cnt), 32'd0);
    check("midrun_reset busy", 32'(busy), 32'd0);
    check("midrun_reset done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    saw_done = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    check("midrun_reset no_done", 32'(saw_done), 32'd0);
    run_check("after_reset", 8'h01, RULE_XOR, 8'd2, 8'h41, 8'd2, 1'b0, 1'b0);

    for (int t = 0; t < 20; t++) begin
      logic [7:0] sd, g;
      logic [3:0] r;
      sd = 8'($urandom);
      r  = 4'($urandom);
      g  = 8'($urandom_range(0, 20));
      model_run(sd, r, g, fs, fc, fst);
      run_check($sformatf("rand%0d", t), sd, r, g, fs, fc, fst, 1'(t % 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
